// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetch packets between fetch and decode.
// Define IF_ID_QUEUE_BYPASS_EN to forward a packet straight to decode while the queue is empty.
package if_id_queue_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } if_id_data_t;
endpackage

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enq_valid_i,
    input  if_id_data_t                  enq_data_i,
    output logic                         enq_ready_o,
    output logic                         deq_valid_o,
    output if_id_data_t                  deq_data_o,
    input  logic                         deq_ready_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    if_id_data_t     r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_store;
    logic            w_pop;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign enq_ready_o = !w_full && !flush_i;
    assign count_o     = r_count;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic w_bypass;
    // rst_n gates the forward path so decode sees nothing while reset is held.
    assign w_bypass    = w_empty && !flush_i && rst_n;
    assign deq_valid_o = w_bypass ? enq_valid_i : (!w_empty && !flush_i);
    assign deq_data_o  = !w_empty ? r_mem[r_rd_ptr] :
                         (w_bypass ? enq_data_i : '0);
    // A packet forwarded and consumed in the same cycle never lands in storage.
    assign w_store     = enq_valid_i && enq_ready_o && !(w_bypass && deq_ready_i);
    assign w_pop       = deq_valid_o && deq_ready_i && !w_empty;
`else
    assign deq_valid_o = !w_empty && !flush_i;
    assign deq_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_store     = enq_valid_i && enq_ready_o;
    assign w_pop       = deq_valid_o && deq_ready_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never cleared; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_store) begin
            r_mem[r_wr_ptr] <= enq_data_i;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic against a queue model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int OW    = 2 + CW + $bits(if_id_data_t);
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [OW-1:0] obs_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enq_valid_i;
    if_id_data_t     enq_data_i;
    logic            enq_ready_o;
    logic            deq_valid_o;
    if_id_data_t     deq_data_o;
    logic            deq_ready_i;
    logic            flush_i;
    logic [CW-1:0]   count_o;

    int n_checks = 0;
    int n_errors = 0;
    if_id_data_t model_q[$];
    obs_t obs;
    obs_t exp;

    // clock / reset
    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_valid_i (enq_valid_i),
        .enq_data_i  (enq_data_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_data_o  (deq_data_o),
        .deq_ready_i (deq_ready_i),
        .flush_i     (flush_i),
        .count_o     (count_o)
    );

    function automatic if_id_data_t make_pkt(input logic [31:0] pc);
        if_id_data_t p;
        p.instr     = $urandom;
        p.pc        = pc;
        p.pc_plus_4 = pc + 32'd4;
        return p;
    endfunction

    // Expected outputs from the model queue and the currently driven inputs.
    function automatic obs_t model_obs();
        logic        rdy, vld;
        if_id_data_t dat;
        int          sz = model_q.size();
        rdy = (sz != DEPTH) && !flush_i;
        if (sz > 0) begin
            vld = !flush_i;
            dat = model_q[0];
        end else if (BYP && !flush_i) begin
            vld = enq_valid_i;
            dat = enq_data_i;
        end else begin
            vld = 1'b0;
            dat = '0;
        end
        return {rdy, vld, CW'(sz), dat};
    endfunction

    // driver tasks
    task automatic drive(input logic ev, input if_id_data_t ed, input logic dr, input logic fl);
        enq_valid_i = ev;
        enq_data_i  = ed;
        deq_ready_i = dr;
        flush_i     = fl;
        #1;
    endtask

    task automatic tick();
        bit full  = (model_q.size() == DEPTH);
        bit empty = (model_q.size() == 0);
        bit taken = BYP && empty && enq_valid_i && deq_ready_i;
        bit pop   = !empty && deq_ready_i;
        bit push  = enq_valid_i && !full && !taken;
        if_id_data_t d = enq_data_i;
        if (!rst_n || flush_i) begin
            model_q.delete();
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid_i = 1'b0;
        enq_data_i  = '0;
        deq_ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, make_pkt(32'h40), 1'b1, 1'b0);
        tick();
        tick();
        idle();
        #1;
        obs = {enq_ready_o, deq_valid_o, count_o, deq_data_o};
        exp = {1'b1, 1'b0, CW'(0), {$bits(if_id_data_t){1'b0}}};
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h want %h", obs, exp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, make_pkt(32'(i * 4)), 1'b0, 1'b0);
            obs = {enq_ready_o, deq_valid_o, count_o, deq_data_o};
            exp = model_obs();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL fill_step%0d: got %h want %h", i, obs, exp);
            end
            tick();
        end
        drive(1'b1, make_pkt(32'h80), 1'b0, 1'b0);
        n_checks++;
        if (count_o !== CW'(4) || enq_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL full_state: got count=%0d ready=%0b want count=4 ready=0", count_o, enq_ready_o);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            obs = {enq_ready_o, deq_valid_o, count_o, deq_data_o};
            exp = model_obs();
            n_checks++;
            if (obs !== exp || deq_data_o.pc !== 32'(i * 4)) begin
                n_errors++;
                $display("FAIL drain_step%0d: got %h want %h (pc want %h)", i, obs, exp, i * 4);
            end
            tick();
        end
        n_checks++;
        if (count_o !== CW'(0) || deq_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL drained: got count=%0d valid=%0b want count=0 valid=0", count_o, deq_valid_o);
        end
        idle();
    endtask

    task automatic test_wrap();
        int sent = 0;
        int rcv  = 0;
        for (int c = 0; c < 100 && rcv < 10; c++) begin
            drive(sent < 10, make_pkt(32'(sent * 4)), 1'(c % 2), 1'b0);
            obs = {enq_ready_o, deq_valid_o, count_o, deq_data_o};
            exp = model_obs();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL wrap_cycle%0d: got %h want %h", c, obs, exp);
            end
            if (deq_valid_o && deq_ready_i) begin
                n_checks++;
                if (deq_data_o.pc !== 32'(rcv * 4)) begin
                    n_errors++;
                    $display("FAIL wrap_order: got pc %h want %h", deq_data_o.pc, rcv * 4);
                end
                rcv++;
            end
            if (enq_valid_i && enq_ready_o) sent++;
            tick();
        end
        n_checks++;
        if (rcv != 10) begin
            n_errors++;
            $display("FAIL wrap_complete: got %0d packets want 10", rcv);
        end
        idle();
    endtask

    task automatic test_simultaneous();
        drive(1'b1, make_pkt(32'h300), 1'b0, 1'b0); tick();
        drive(1'b1, make_pkt(32'h304), 1'b0, 1'b0); tick();
        drive(1'b1, make_pkt(32'h308), 1'b1, 1'b0);
        n_checks++;
        if (count_o !== CW'(2) || deq_data_o.pc !== 32'h300) begin
            n_errors++;
            $display("FAIL simul_before: got count=%0d pc=%h want count=2 pc=300", count_o, deq_data_o.pc);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (count_o !== CW'(2) || deq_data_o.pc !== 32'h304) begin
            n_errors++;
            $display("FAIL simul_after: got count=%0d pc=%h want count=2 pc=304", count_o, deq_data_o.pc);
        end
        drive(1'b0, '0, 1'b0, 1'b1); tick();
        idle();
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, make_pkt(32'h400 + 32'(i * 4)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, make_pkt(32'h410), 1'b1, 1'b0);
        n_checks++;
        if (enq_ready_o !== 1'b0 || deq_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL full_deq_hs: got ready=%0b valid=%0b want ready=0 valid=1", enq_ready_o, deq_valid_o);
        end
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (count_o !== CW'(4 - i) || deq_data_o.pc !== 32'h400 + 32'(i * 4)) begin
                n_errors++;
                $display("FAIL full_deq_%0d: got count=%0d pc=%h want count=%0d pc=%h",
                         i, count_o, deq_data_o.pc, 4 - i, 32'h400 + 32'(i * 4));
            end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (count_o !== CW'(0)) begin
            n_errors++;
            $display("FAIL full_deq_end: got count=%0d want 0", count_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, make_pkt(32'h500 + 32'(i * 4)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, make_pkt(32'h100), 1'b1, 1'b1);
        n_checks++;
        if (enq_ready_o !== 1'b0 || deq_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_hs: got ready=%0b valid=%0b want 0 0", enq_ready_o, deq_valid_o);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (count_o !== CW'(0) || deq_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_after: got count=%0d valid=%0b want 0 0", count_o, deq_valid_o);
        end
        drive(1'b1, make_pkt(32'h104), 1'b0, 1'b0);
        n_checks++;
        if (enq_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_resume_ready: got %0b want 1", enq_ready_o);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (count_o !== CW'(1) || deq_data_o.pc !== 32'h104) begin
            n_errors++;
            $display("FAIL flush_resume: got count=%0d pc=%h want count=1 pc=104", count_o, deq_data_o.pc);
        end
        drive(1'b0, '0, 1'b0, 1'b1); tick();
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, make_pkt(32'h600), 1'b0, 1'b0); tick();
        drive(1'b1, make_pkt(32'h604), 1'b0, 1'b0); tick();
        rst_n = 1'b0;
        drive(1'b1, make_pkt(32'h608), 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        n_checks++;
        if (count_o !== CW'(0) || enq_ready_o !== 1'b1 || deq_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got count=%0d ready=%0b valid=%0b want 0 1 0",
                     count_o, enq_ready_o, deq_valid_o);
        end
`ifdef IF_ID_QUEUE_BYPASS_EN
        drive(1'b1, make_pkt(32'h200), 1'b1, 1'b0);
        n_checks++;
        if (deq_valid_o !== 1'b1 || deq_data_o.pc !== 32'h200) begin
            n_errors++;
            $display("FAIL bypass_fwd: got valid=%0b pc=%h want 1 200", deq_valid_o, deq_data_o.pc);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (count_o !== CW'(0)) begin
            n_errors++;
            $display("FAIL bypass_count: got %0d want 0", count_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 99) < 60), make_pkt(pc), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 4));
            obs = {enq_ready_o, deq_valid_o, count_o, deq_data_o};
            exp = model_obs();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %h want %h", c, obs, exp);
            end
            if (enq_valid_i && enq_ready_o) pc = pc + 32'd4;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_full_deq();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
